// File: rtl/lc3_pkg.sv
// Shared LC-3 controller definitions: opcodes, FSM state encodings, ALU ops,
// condition-code values and the immediate/offset sign-extension helpers.
package lc3_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'b000,
        S_LOADIR = 3'b001,
        S_DECODE = 3'b010,
        S_EXEC   = 3'b011,
        S_MEM    = 3'b100,
        S_WB     = 3'b101,
        S_HALT   = 3'b110
    } state_t;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_AND = 2'b01;
    localparam logic [1:0] ALU_NOT = 2'b10;

    localparam logic [2:0] CC_N = 3'b100;
    localparam logic [2:0] CC_Z = 3'b010;
    localparam logic [2:0] CC_P = 3'b001;

    function automatic logic [15:0] sext_imm5(input logic [4:0] v);
        return {{11{v[4]}}, v};
    endfunction

    function automatic logic [15:0] sext_off9(input logic [8:0] v);
        return {{7{v[8]}}, v};
    endfunction

endpackage

// File: rtl/lc3_cc_logic.sv
// Combinational NZP classification of a 16-bit two's-complement value.
module lc3_cc_logic
    import lc3_pkg::*;
(
    input  logic [15:0] value,
    output logic [2:0]  nzp
);

    always_comb begin
        if (value == 16'h0000)
            nzp = CC_Z;
        else if (value[15])
            nzp = CC_N;
        else
            nzp = CC_P;
    end

endmodule

// File: rtl/lc3_ctrl_fsm.sv
// LC-3 multi-cycle controller: FSM plus PC/MAR/MDR/IR/CC, driving an external
// register file, 128-word memory and ALU and consuming their read data.
module lc3_ctrl_fsm
    import lc3_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          MEM_AW   = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [15:0]       mem_d_in,
    output logic              mem_we,
    input  logic [15:0]       mem_d_out,
    output logic [2:0]        regfile_DR,
    output logic [2:0]        regfile_SR1_addr,
    output logic [2:0]        regfile_SR2_addr,
    output logic [15:0]       regfile_d,
    output logic              regfile_we,
    input  logic [15:0]       regfile_SR1_out,
    input  logic [15:0]       regfile_SR2_out,
    output logic [15:0]       alu_operand1,
    output logic [15:0]       alu_operand2,
    output logic [3:0]        alu_opcode,
    input  logic [15:0]       alu_out,
    output logic [15:0]       pc_out,
    output logic [15:0]       ir_out,
    output logic [2:0]        state_out,
    output logic              halted,
    output logic              illegal
);

    state_t state, state_nxt;

    logic [15:0]       pc, mdr, ir;
    // Only the low address bits ever reach memory, so only those are kept.
    logic [MEM_AW-1:0] mar;
    logic [2:0]        cc, cc_new;
    logic              illegal_q;
    logic [3:0]        opcode;
    logic [15:0]       pc_off;
    logic              br_taken, known_op;
    logic [1:0]        alu_op;

    assign opcode   = ir[15:12];
    assign pc_off   = pc + sext_off9(ir[8:0]);
    assign br_taken = |(ir[11:9] & cc);
    assign known_op = opcode inside {OP_BR, OP_ADD, OP_LD, OP_ST, OP_AND, OP_NOT, OP_TRAP};

    always_comb begin
        case (opcode)
            OP_AND:  alu_op = ALU_AND;
            OP_NOT:  alu_op = ALU_NOT;
            default: alu_op = ALU_ADD;
        endcase
    end

    assign mem_addr         = mar;
    assign mem_d_in         = regfile_SR1_out;
    assign regfile_DR       = ir[11:9];
    assign regfile_SR1_addr = (opcode == OP_ST) ? ir[11:9] : ir[8:6];
    assign regfile_SR2_addr = ir[2:0];
    assign regfile_d        = (state == S_WB) ? mdr : alu_out;
    assign alu_operand1     = regfile_SR1_out;
    assign alu_operand2     = ir[5] ? sext_imm5(ir[4:0]) : regfile_SR2_out;
    assign alu_opcode       = {2'b00, alu_op};
    assign pc_out           = pc;
    assign ir_out           = ir;
    assign state_out        = state;
    assign halted           = (state == S_HALT);
    assign illegal          = illegal_q;

    // Flags follow whatever value is being written back this cycle.
    lc3_cc_logic u_cc (
        .value (regfile_d),
        .nzp   (cc_new)
    );

    always_ff @(posedge clk) begin
        if (!rst)
            state <= S_FETCH;
        else
            state <= state_nxt;
    end

    // Write strobes are qualified by rst so a reset mid-instruction never commits.
    always_comb begin
        state_nxt  = state;
        mem_we     = 1'b0;
        regfile_we = 1'b0;
        case (state)
            S_FETCH:  if (run) state_nxt = S_LOADIR;
            S_LOADIR: state_nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_ADD, OP_AND, OP_NOT: state_nxt = S_EXEC;
                    OP_LD, OP_ST:           state_nxt = S_MEM;
                    OP_TRAP:                state_nxt = S_HALT;
                    default:                state_nxt = S_FETCH;
                endcase
            end
            S_EXEC: begin
                regfile_we = rst;
                state_nxt  = S_FETCH;
            end
            S_MEM: begin
                if (opcode == OP_LD) begin
                    state_nxt = S_WB;
                end else begin
                    mem_we    = rst;
                    state_nxt = S_FETCH;
                end
            end
            S_WB: begin
                regfile_we = rst;
                state_nxt  = S_FETCH;
            end
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc        <= RESET_PC;
            mar       <= '0;
            mdr       <= 16'h0000;
            ir        <= 16'h0000;
            cc        <= CC_Z;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (run) begin
                        mar <= pc[MEM_AW-1:0];
                        pc  <= pc + 16'd1;
                    end
                end
                S_LOADIR: ir <= mem_d_out;
                S_DECODE: begin
                    if (opcode == OP_LD || opcode == OP_ST)
                        mar <= pc_off[MEM_AW-1:0];
                    if (opcode == OP_BR && br_taken)
                        pc <= pc_off;
                    if (!known_op)
                        illegal_q <= 1'b1;
                end
                S_EXEC, S_WB: cc <= cc_new;
                S_MEM: begin
                    if (opcode == OP_LD)
                        mdr <= mem_d_out;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_ctrl_fsm.sv
// Bench for lc3_ctrl_fsm: hosts memory, register file and ALU, and checks the
// controller against an instruction-level LC-3 model every cycle.
`timescale 1ns/1ps
module tb_lc3_ctrl_fsm;

    logic        clk, rst, run;
    logic [6:0]  mem_addr;
    logic [15:0] mem_d_in, mem_d_out;
    logic        mem_we;
    logic [2:0]  regfile_DR, regfile_SR1_addr, regfile_SR2_addr;
    logic [15:0] regfile_d, regfile_SR1_out, regfile_SR2_out;
    logic        regfile_we;
    logic [15:0] alu_operand1, alu_operand2, alu_out;
    logic [3:0]  alu_opcode;
    logic [15:0] pc_out, ir_out;
    logic [2:0]  state_out;
    logic        halted, illegal;

    lc3_ctrl_fsm dut (
        .clk(clk), .rst(rst), .run(run),
        .mem_addr(mem_addr), .mem_d_in(mem_d_in), .mem_we(mem_we), .mem_d_out(mem_d_out),
        .regfile_DR(regfile_DR), .regfile_SR1_addr(regfile_SR1_addr),
        .regfile_SR2_addr(regfile_SR2_addr), .regfile_d(regfile_d), .regfile_we(regfile_we),
        .regfile_SR1_out(regfile_SR1_out), .regfile_SR2_out(regfile_SR2_out),
        .alu_operand1(alu_operand1), .alu_operand2(alu_operand2), .alu_opcode(alu_opcode),
        .alu_out(alu_out), .pc_out(pc_out), .ir_out(ir_out), .state_out(state_out),
        .halted(halted), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment: memory, register file, ALU, plus a bench-side loader port.
    logic [15:0] mem [0:127];
    logic [15:0] R   [0:7];
    logic        ld_we, ld_rwe;
    logic [6:0]  ld_addr;
    logic [2:0]  ld_raddr;
    logic [15:0] ld_data, ld_rdata;

    assign mem_d_out       = mem[mem_addr];
    assign regfile_SR1_out = R[regfile_SR1_addr];
    assign regfile_SR2_out = R[regfile_SR2_addr];

    always_comb begin
        case (alu_opcode)
            4'd0:    alu_out = alu_operand1 + alu_operand2;
            4'd1:    alu_out = alu_operand1 & alu_operand2;
            4'd2:    alu_out = ~alu_operand1;
            default: alu_out = 16'h0000;
        endcase
    end

    always @(posedge clk) begin
        if (mem_we)     mem[mem_addr]   <= mem_d_in;
        if (regfile_we) R[regfile_DR]   <= regfile_d;
        if (ld_we)      mem[ld_addr]    <= ld_data;
        if (ld_rwe)     R[ld_raddr]     <= ld_rdata;
    end

    // Instruction-level reference model.
    logic [15:0] mm [0:127];
    logic [15:0] mr [0:7];
    logic [15:0] mpc;
    logic [2:0]  mcc;
    logic        mill;
    int          errors = 0;
    int          checks = 0;
    logic [3:0]  ill_tab [0:8];

    function automatic logic [15:0] sx9(input logic [8:0] x);
        return {{7{x[8]}}, x};
    endfunction

    function automatic logic [15:0] sx5(input logic [4:0] x);
        return {{11{x[4]}}, x};
    endfunction

    function automatic logic [2:0] ccf(input logic [15:0] v);
        if (v == 16'h0000) return 3'b010;
        if (v[15]) return 3'b100;
        return 3'b001;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_mem(input logic [6:0] a, input logic [15:0] d);
        ld_we = 1'b1; ld_addr = a; ld_data = d;
        mm[a] = d;
        @(negedge clk);
        ld_we = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        run = 1'($urandom);
        #1;
        chk("rst_we", 32'({mem_we, regfile_we}), 32'd0);
        @(negedge clk);
        chk("rst_we2", 32'({mem_we, regfile_we}), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run = 1'b0;
        chk("rst_state", 32'(state_out), 32'd0);
        chk("rst_pc", 32'(pc_out), 32'h0000);
        chk("rst_ir", 32'(ir_out), 32'h0000);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        mpc = 16'h0000; mcc = 3'b010; mill = 1'b0;
    endtask

    // Runs the instruction at the model PC, checking every cycle; abort_at>=0
    // asserts reset during that cycle of the instruction instead of finishing it.
    task automatic step(input int idle, input int abort_at);
        logic [15:0] ins, pc_n, ea, v;
        logic [3:0]  op;
        logic [2:0]  dr, sr1;
        logic [2:0]  seq [0:5];
        logic [1:0]  exp_we;
        int          n, ndiff;
        for (int i = 0; i < idle; i++) begin
            chk("idle_state", 32'(state_out), 32'd0);
            chk("idle_pc", 32'(pc_out), 32'(mpc));
            @(negedge clk);
        end
        ins  = mm[mpc[6:0]];
        op   = ins[15:12];
        dr   = ins[11:9];
        sr1  = ins[8:6];
        pc_n = mpc + 16'd1;
        ea   = pc_n + sx9(ins[8:0]);
        v    = 16'h0000;
        seq[0] = 3'd0; seq[1] = 3'd1; seq[2] = 3'd2; seq[3] = 3'd0; seq[4] = 3'd0; seq[5] = 3'd0;
        n = 3;
        case (op)
            4'h1: begin v = mr[sr1] + (ins[5] ? sx5(ins[4:0]) : mr[ins[2:0]]); seq[3] = 3'd3; n = 4; end
            4'h5: begin v = mr[sr1] & (ins[5] ? sx5(ins[4:0]) : mr[ins[2:0]]); seq[3] = 3'd3; n = 4; end
            4'h9: begin v = ~mr[sr1]; seq[3] = 3'd3; n = 4; end
            4'h2: begin v = mm[ea[6:0]]; seq[3] = 3'd4; seq[4] = 3'd5; n = 5; end
            4'h3: begin seq[3] = 3'd4; n = 4; end
            4'hF: begin seq[3] = 3'd6; n = 4; end
            default: ;
        endcase
        run = 1'b1;
        for (int k = 0; k < n; k++) begin
            chk("state", 32'(state_out), 32'(seq[k]));
            exp_we = 2'b00;
            if (seq[k] == 3'd3 || seq[k] == 3'd5) exp_we = 2'b01;
            if (seq[k] == 3'd4 && op == 4'h3) exp_we = 2'b10;
            chk("we", 32'({mem_we, regfile_we}), 32'(exp_we));
            if (seq[k] == 3'd1) chk("fetch_addr", 32'(mem_addr), 32'(mpc[6:0]));
            if (seq[k] == 3'd4) chk("mem_addr", 32'(mem_addr), 32'(ea[6:0]));
            if (seq[k] == 3'd4 && op == 4'h3) chk("st_data", 32'(mem_d_in), 32'(mr[dr]));
            if (seq[k] == 3'd3 || seq[k] == 3'd5) begin
                chk("wr_reg", 32'(regfile_DR), 32'(dr));
                chk("wr_data", 32'(regfile_d), 32'(v));
            end
            if (k == abort_at) begin
                do_reset();
                return;
            end
            @(negedge clk);
            run = 1'($urandom);
        end
        run = 1'b0;
        mpc = pc_n;
        case (op)
            4'h1, 4'h5, 4'h9, 4'h2: begin mr[dr] = v; mcc = ccf(v); end
            4'h3: mm[ea[6:0]] = mr[dr];
            4'h0: if (|(dr & mcc)) mpc = ea;
            4'hF: ;
            default: mill = 1'b1;
        endcase
        chk("pc", 32'(pc_out), 32'(mpc));
        chk("ir", 32'(ir_out), 32'(ins));
        chk("illegal", 32'(illegal), 32'(mill));
        chk("halted", 32'(halted), 32'(op == 4'hF));
        for (int i = 0; i < 8; i++) chk("reg", 32'(R[i]), 32'(mr[i]));
        ndiff = 0;
        for (int i = 0; i < 128; i++) if (mem[i] !== mm[i]) ndiff++;
        chk("mem_words_diff", 32'(ndiff), 32'd0);
    endtask

    initial begin
        logic [15:0] ins;
        logic [3:0]  op;
        ill_tab = '{4'h4, 4'h6, 4'h7, 4'h8, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE};
        rst = 1'b0; run = 1'b0;
        ld_we = 1'b0; ld_rwe = 1'b0; ld_addr = '0; ld_raddr = '0; ld_data = '0; ld_rdata = '0;
        @(negedge clk);
        for (int i = 0; i < 128; i++) begin
            ld_we = 1'b1; ld_addr = 7'(i); ld_data = 16'($urandom);
            mm[i] = ld_data;
            @(negedge clk);
        end
        ld_we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ld_rwe = 1'b1; ld_raddr = 3'(i); ld_rdata = 16'h0000;
            mr[i] = 16'h0000;
            @(negedge clk);
        end
        ld_rwe = 1'b0;
        chk("reset_state", 32'(state_out), 32'd0);
        chk("reset_pc", 32'(pc_out), 32'h0000);
        chk("reset_ir", 32'(ir_out), 32'h0000);
        chk("reset_we", 32'({mem_we, regfile_we}), 32'd0);
        chk("reset_halted", 32'(halted), 32'd0);
        chk("reset_illegal", 32'(illegal), 32'd0);
        rst = 1'b1;
        mpc = 16'h0000; mcc = 3'b010; mill = 1'b0;

        // Directed program with hand-computed results.
        set_mem(7'd0, 16'h1225);  set_mem(7'd1, 16'h5460);  set_mem(7'd2, 16'h96BF);
        set_mem(7'd3, 16'h0000);  set_mem(7'd4, 16'h2802);  set_mem(7'd5, 16'h3803);
        set_mem(7'd6, 16'h0E03);  set_mem(7'd7, 16'h1234);  set_mem(7'd10, 16'h05FE);
        set_mem(7'd11, 16'h5B60); set_mem(7'd12, 16'h0FFD);
        chk("hold_pc", 32'(pc_out), 32'h0000);
        step(3, -1); chk("lit_R1", 32'(R[1]), 32'h0005); chk("lit_pc1", 32'(pc_out), 32'h0001);
        step(0, -1); chk("lit_R2", 32'(R[2]), 32'h0000);
        step(1, -1); chk("lit_R3", 32'(R[3]), 32'hFFFF);
        step(0, -1); chk("lit_pc4", 32'(pc_out), 32'h0004);
        step(0, -1); chk("lit_R4", 32'(R[4]), 32'h1234);
        step(0, -1); chk("lit_mem9", 32'(mem[9]), 32'h1234);
        step(0, -1); chk("lit_pc10", 32'(pc_out), 32'h000A);
        step(0, -1); chk("lit_brz_nt", 32'(pc_out), 32'h000B);
        step(0, -1); chk("lit_R5", 32'(R[5]), 32'h0000);
        step(0, -1); chk("lit_pc10b", 32'(pc_out), 32'h000A);
        step(0, -1); chk("lit_brz_t", 32'(pc_out), 32'h0009);
        set_mem(7'd9, 16'h0FF6);  step(0, -1); chk("lit_pc0", 32'(pc_out), 32'h0000);
        set_mem(7'd0, 16'h0FFF);  step(0, -1); chk("lit_self", 32'(pc_out), 32'h0000);
        set_mem(7'd0, 16'h0FFE);  step(0, -1); chk("lit_pcFFFF", 32'(pc_out), 32'hFFFF);
        set_mem(7'h7F, 16'h1C27); step(0, -1);
        chk("lit_wrap_pc", 32'(pc_out), 32'h0000); chk("lit_R6", 32'(R[6]), 32'h0007);
        set_mem(7'd0, 16'h4000);  step(0, -1); chk("lit_illegal", 32'(illegal), 32'd1);

        // Randomized instruction stream.
        for (int t = 0; t < 250; t++) begin
            case ($urandom_range(0, 7))
                0: op = 4'h1;
                1: op = 4'h5;
                2: op = 4'h9;
                3: op = 4'h2;
                4: op = 4'h3;
                5, 6: op = 4'h0;
                default: op = ill_tab[$urandom_range(0, 8)];
            endcase
            ins = {op, 12'($urandom)};
            set_mem(mpc[6:0], ins);
            step($urandom_range(0, 2), -1);
        end

        // TRAP halts and ignores run.
        set_mem(mpc[6:0], 16'hF025);
        step(0, -1);
        run = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("halt_state", 32'(state_out), 32'd6);
            chk("halt_flag", 32'(halted), 32'd1);
            chk("halt_we", 32'({mem_we, regfile_we}), 32'd0);
            chk("halt_pc", 32'(pc_out), 32'(mpc));
        end
        run = 1'b0;
        do_reset();

        // Reset landing in the MEM cycle of LD and of ST must not commit.
        set_mem(7'd0, 16'h2802); set_mem(7'd3, ~mr[4]);
        step(0, 3);
        chk("abort_ld_reg", 32'(R[4]), 32'(mr[4]));
        set_mem(7'd0, 16'h3803); set_mem(7'd4, ~mr[4]);
        step(0, 3);
        chk("abort_st_mem", 32'(mem[4]), 32'(mm[4]));
        set_mem(7'd0, 16'h0401);
        step(0, -1); chk("lit_cc_reset", 32'(pc_out), 32'h0002);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
